// File: rtl/s_coef_fetcher_pkg.sv
// Shared S-RAM dimensions and width helper for the PEA coefficient path.
// Imported by the fetcher and any block that must agree on RAM geometry.
package s_coef_fetcher_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int NUM_VECTORS = 8;
  localparam int MAX_DEGREE  = 10;

  // Ceiling log2: bits needed to index v distinct values.
  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/s_coef_fetcher.sv
// Read-side sequencer for the S coefficient RAM: walks one polynomial
// from its top coefficient down to 0 and streams words to the PEA.
module s_coef_fetcher
  import s_coef_fetcher_pkg::*;
#(
  parameter int word_size   = WORD_SIZE,
  parameter int num_vectors = NUM_VECTORS,
  parameter int max_degree  = MAX_DEGREE,
  localparam int VW = log2(num_vectors),
  localparam int CW = log2(max_degree) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VW-1:0]        vector_index,
  input  logic [CW-1:0]        degree,
  output logic [VW-1:0]        rd_vector_addr,
  output logic [CW-1:0]        rd_coef_addr,
  output logic                 re_en,
  input  logic [word_size-1:0] q,
  input  logic                 q_en,
  output logic [word_size-1:0] coef_out,
  output logic [CW-1:0]        coef_index,
  output logic                 coef_valid,
  input  logic                 coef_ready,
  output logic                 coef_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [CW-1:0] MAXD = CW'(max_degree);

  logic [1:0]    state;
  logic [CW-1:0] idx;

  // re_en is raised on the edge that enters ISSUE, so the read is
  // already on the bus during the ISSUE cycle; ISSUE just waits it out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      rd_vector_addr <= '0;
      rd_coef_addr   <= '0;
      re_en          <= 1'b0;
      coef_out       <= '0;
      coef_index     <= '0;
      coef_valid     <= 1'b0;
      coef_last      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      re_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (degree > MAXD) begin
              err <= 1'b1;
            end else begin
              idx            <= degree;
              rd_vector_addr <= vector_index;
              rd_coef_addr   <= degree;
              re_en          <= 1'b1;
              busy           <= 1'b1;
              state          <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (q_en) begin
            coef_out   <= q;
            coef_index <= idx;
            coef_valid <= 1'b1;
            coef_last  <= (idx == '0);
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (coef_ready) begin
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            if (idx == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              idx          <= idx - 1'b1;
              rd_coef_addr <= idx - 1'b1;
              re_en        <= 1'b1;
              state        <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_coef_fetcher.sv
// Directed bench for s_coef_fetcher with a registered-read RAM model
// and a queue of expected stream words checked on each transfer.
module tb_s_coef_fetcher;
  import s_coef_fetcher_pkg::*;

  localparam int W  = 16;
  localparam int VW = 3;
  localparam int CW = 5;

  typedef struct {
    logic [W-1:0]  c;
    logic [CW-1:0] i;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VW-1:0] vector_index;
  logic [CW-1:0] degree;
  logic [VW-1:0] rd_vector_addr;
  logic [CW-1:0] rd_coef_addr;
  logic          re_en;
  logic [W-1:0]  q;
  logic          q_en;
  logic [W-1:0]  coef_out;
  logic [CW-1:0] coef_index;
  logic          coef_valid;
  logic          coef_ready;
  logic          coef_last;
  logic          busy;
  logic          done;
  logic          err;

  logic [W-1:0] mem [8][11];
  logic         q_en_r = 1'b0;
  logic         q_force;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   re_total = 0;

  always #5 clk = ~clk;

  s_coef_fetcher dut (
    .clk(clk), .rst(rst), .start(start),
    .vector_index(vector_index), .degree(degree),
    .rd_vector_addr(rd_vector_addr), .rd_coef_addr(rd_coef_addr),
    .re_en(re_en), .q(q), .q_en(q_en),
    .coef_out(coef_out), .coef_index(coef_index),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_last(coef_last), .busy(busy), .done(done), .err(err)
  );

  assign q_en = q_en_r | q_force;

  always @(posedge clk) begin
    q_en_r <= re_en;
    if (re_en) q <= mem[rd_vector_addr][rd_coef_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (re_en) re_total++;
    if (!rst && coef_valid && coef_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", 32'(coef_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("coef_out", 32'(coef_out), 32'(e.c));
        chk("coef_index", 32'(coef_index), 32'(e.i));
        chk("coef_last", 32'(coef_last), 32'(e.l));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] c, input int i, input logic l);
    exp_t e;
    e.c = c;
    e.i = CW'(i);
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic start_fetch(input int v, input int d);
    start = 1'b1;
    vector_index = VW'(v);
    degree = CW'(d);
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 32'(n), 32'd0);
  endtask

  int n;
  int re0;

  initial begin
    for (int v = 0; v < 8; v++)
      for (int i = 0; i < 11; i++)
        mem[v][i] = 16'((v << 12) | i);
    for (int i = 0; i < 11; i++) mem[3][i] = 16'(16'h0100 + i);
    mem[7][0] = 16'hBEEF;
    mem[7][1] = 16'h7771;

    rst = 1'b1;
    start = 1'b0;
    vector_index = '0;
    degree = '0;
    coef_ready = 1'b1;
    q_force = 1'b0;
    tick();
    tick();
    chk("rst_re_en", 32'(re_en), 0);
    chk("rst_valid", 32'(coef_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_coef_out", 32'(coef_out), 0);
    chk("rst_rd_coef_addr", 32'(rd_coef_addr), 0);
    rst = 1'b0;
    tick();

    // Full degree-10 fetch of vector 3
    for (int i = 10; i >= 0; i--) push(16'(16'h0100 + i), i, i == 0);
    re0 = re_total;
    start_fetch(3, 10);
    chk("t1_busy_e0", 32'(busy), 1);
    chk("t1_re_en_e0", 32'(re_en), 1);
    chk("t1_addr_e0", 32'({rd_vector_addr, rd_coef_addr}), 32'({3'd3, 5'd10}));
    run_to_done(n);
    chk("t1_done_cycle", 32'(n), 33);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_re_count", 32'(re_total - re0), 11);
    chk("t1_sb_empty", 32'(sb.size()), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);

    // Degree 0 on vector 7: cycle-exact latency
    push(16'hBEEF, 0, 1'b1);
    re0 = re_total;
    start_fetch(7, 0);
    chk("t2_re_e0", 32'(re_en), 1);
    tick();
    chk("t2_re_e1", 32'(re_en), 0);
    chk("t2_valid_e1", 32'(coef_valid), 0);
    tick();
    chk("t2_valid_e2", 32'(coef_valid), 1);
    chk("t2_last_e2", 32'(coef_last), 1);
    tick();
    chk("t2_done_e3", 32'(done), 1);
    chk("t2_valid_e3", 32'(coef_valid), 0);
    chk("t2_re_count", 32'(re_total - re0), 1);
    chk("t2_sb_empty", 32'(sb.size()), 0);
    tick();

    // Backpressure
    coef_ready = 1'b0;
    push(16'h0101, 1, 1'b0);
    push(16'h0100, 0, 1'b1);
    start_fetch(3, 1);
    n = 0;
    while (!coef_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t3_valid", 32'(coef_valid), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_out", 32'(coef_out), 32'h0101);
      chk("t3_hold_idx", 32'(coef_index), 1);
      chk("t3_hold_valid", 32'(coef_valid), 1);
      chk("t3_hold_re", 32'(re_en), 0);
    end
    coef_ready = 1'b1;
    tick();
    chk("t3_xfer_valid", 32'(coef_valid), 0);
    chk("t3_xfer_re", 32'(re_en), 1);
    run_to_done(n);
    chk("t3_sb_empty", 32'(sb.size()), 0);
    tick();

    // Illegal degree
    re0 = re_total;
    start_fetch(2, 11);
    chk("t4_err", 32'(err), 1);
    chk("t4_busy", 32'(busy), 0);
    tick();
    chk("t4_err_off", 32'(err), 0);
    for (int k = 0; k < 4; k++) tick();
    chk("t4_no_re", 32'(re_total - re0), 0);
    chk("t4_busy_later", 32'(busy), 0);

    // Start while busy ignored; start in done cycle accepted
    push(16'h7771, 1, 1'b0);
    push(16'hBEEF, 0, 1'b1);
    re0 = re_total;
    start_fetch(7, 1);
    tick();
    start = 1'b1;
    vector_index = 3'd3;
    degree = 5'd5;
    tick();
    start = 1'b0;
    run_to_done(n);
    chk("t5_re_count", 32'(re_total - re0), 2);
    push(16'h0100, 0, 1'b1);
    start_fetch(3, 0);
    chk("t5_b2b_re", 32'(re_en), 1);
    chk("t5_b2b_vec", 32'(rd_vector_addr), 3);
    chk("t5_b2b_coef", 32'(rd_coef_addr), 0);
    chk("t5_b2b_busy", 32'(busy), 1);
    run_to_done(n);
    chk("t5_sb_empty", 32'(sb.size()), 0);
    tick();

    // Reset in WAIT
    push(16'h0104, 4, 1'b0);
    start_fetch(3, 4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("t6_valid", 32'(coef_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_re_en", 32'(re_en), 0);
    chk("t6_rd_addr", 32'({rd_vector_addr, rd_coef_addr}), 0);
    chk("t6_index", 32'(coef_index), 0);
    q_force = 1'b1;
    tick();
    q_force = 1'b0;
    tick();
    chk("t6_stale_valid", 32'(coef_valid), 0);
    chk("t6_stale_busy", 32'(busy), 0);
    push(16'hBEEF, 0, 1'b1);
    start_fetch(7, 0);
    run_to_done(n);
    chk("t6_after_cycles", 32'(n), 3);
    chk("t6_sb_empty", 32'(sb.size()), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
